// File: rtl/wire_use_blk_if.sv
// Operand and result bundle for wire_use_blk.
// The master drives A/B/D; the slave (the cell) returns E, C, change pulses and the high-time count.
interface wire_use_blk_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] B_i;
    logic [WIDTH-1:0] D_i;
    logic [WIDTH-1:0] E_o;
    logic [WIDTH-1:0] C_o;
    logic [WIDTH-1:0] e_chg_o;
    logic [CNT_W-1:0] e_cnt_o;

    modport master (
        output A_i, B_i, D_i,
        input  E_o, C_o, e_chg_o, e_cnt_o
    );

    modport slave (
        input  A_i, B_i, D_i,
        output E_o, C_o, e_chg_o, e_cnt_o
    );
endinterface

// File: rtl/wire_use_blk.sv
// Registered glue cell: E = (A & B) | D per lane, with change pulses and a saturating high-time counter.
// Optional macro WIRE_USE_INPUT_SYNC_EN inserts a 2-flop input synchroniser (latency 1 -> 3).
module wire_use_blk #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    wire_use_blk_if.slave wu_if
);

    logic [WIDTH-1:0] a_in, b_in, d_in;

`ifdef WIRE_USE_INPUT_SYNC_EN
    logic [WIDTH-1:0] a_s1_q, a_s2_q;
    logic [WIDTH-1:0] b_s1_q, b_s2_q;
    logic [WIDTH-1:0] d_s1_q, d_s2_q;

    // Synchroniser stages clear with the rest of the cell so post-reset
    // outputs are derived from all-zero operands until real data arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_s1_q <= '0;
            a_s2_q <= '0;
            b_s1_q <= '0;
            b_s2_q <= '0;
            d_s1_q <= '0;
            d_s2_q <= '0;
        end else begin
            a_s1_q <= wu_if.A_i;
            a_s2_q <= a_s1_q;
            b_s1_q <= wu_if.B_i;
            b_s2_q <= b_s1_q;
            d_s1_q <= wu_if.D_i;
            d_s2_q <= d_s1_q;
        end
    end

    assign a_in = a_s2_q;
    assign b_in = b_s2_q;
    assign d_in = d_s2_q;
`else
    assign a_in = wu_if.A_i;
    assign b_in = wu_if.B_i;
    assign d_in = wu_if.D_i;
`endif

    logic [WIDTH-1:0] c_d,   c_q;
    logic [WIDTH-1:0] e_d,   e_q;
    logic [WIDTH-1:0] chg_d, chg_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        c_d   = a_in & b_in;
        e_d   = c_d | d_in;
        chg_d = e_d ^ e_q;
        cnt_d = cnt_q;
        // Count on the currently visible E, saturating at all-ones.
        if ((|e_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_q   <= '0;
            e_q   <= '0;
            chg_q <= '0;
            cnt_q <= '0;
        end else begin
            c_q   <= c_d;
            e_q   <= e_d;
            chg_q <= chg_d;
            cnt_q <= cnt_d;
        end
    end

    assign wu_if.C_o     = c_q;
    assign wu_if.E_o     = e_q;
    assign wu_if.e_chg_o = chg_q;
    assign wu_if.e_cnt_o = cnt_q;

endmodule

// File: tb/tb_wire_use_blk.sv
// Scoreboard bench for wire_use_blk: a 1-lane/3-bit-counter cell and a 4-lane/8-bit-counter cell run in lockstep.
// Expected results are queued when operands are driven and compared when the pipeline delivers them.
module tb_wire_use_blk;

`ifdef WIRE_USE_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wire_use_blk_if #(.WIDTH(1), .CNT_W(3)) if1 ();
    wire_use_blk_if #(.WIDTH(4), .CNT_W(8)) if4 ();

    wire_use_blk #(.WIDTH(1), .CNT_W(3)) dut1 (.clk_i(clk), .rst_i(rst), .wu_if(if1.slave));
    wire_use_blk #(.WIDTH(4), .CNT_W(8)) dut4 (.clk_i(clk), .rst_i(rst), .wu_if(if4.slave));

    typedef struct {
        logic [0:0] e1, c1, chg1;
        logic [2:0] cnt1;
        logic [3:0] e4, c4, chg4;
        logic [7:0] cnt4;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: last E value the cell is expected to show, and its count.
    logic [0:0] m1_e;
    logic [2:0] m1_cnt;
    logic [3:0] m4_e;
    logic [7:0] m4_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_push(input logic a1, b1, d1, input logic [3:0] a4, b4, d4);
        exp_t x;
        x.c1   = a1 & b1;
        x.e1   = x.c1 | d1;
        x.chg1 = (x.e1 != m1_e) ? 1'b1 : 1'b0;
        if (m1_e != 0 && m1_cnt < 3'd7) m1_cnt = m1_cnt + 3'd1;
        x.cnt1 = m1_cnt;
        m1_e   = x.e1;
        for (int i = 0; i < 4; i++) begin
            x.c4[i]   = a4[i] & b4[i];
            x.e4[i]   = x.c4[i] | d4[i];
            x.chg4[i] = (x.e4[i] != m4_e[i]) ? 1'b1 : 1'b0;
        end
        if (m4_e != 0 && m4_cnt < 8'd255) m4_cnt = m4_cnt + 8'd1;
        x.cnt4 = m4_cnt;
        m4_e   = x.e4;
        sb_q.push_back(x);
    endtask

    task automatic drive(input logic a1, b1, d1, input logic [3:0] a4, b4, d4);
        if1.A_i = a1; if1.B_i = b1; if1.D_i = d1;
        if4.A_i = a4; if4.B_i = b4; if4.D_i = d4;
    endtask

    task automatic do_reset(input int cycles, input logic a1, b1, d1, input logic [3:0] a4, b4, d4);
        drive(a1, b1, d1, a4, b4, d4);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check("rst_E1",   32'(if1.E_o),     32'd0);
            check("rst_C1",   32'(if1.C_o),     32'd0);
            check("rst_chg1", 32'(if1.e_chg_o), 32'd0);
            check("rst_cnt1", 32'(if1.e_cnt_o), 32'd0);
            check("rst_E4",   32'(if4.E_o),     32'd0);
            check("rst_cnt4", 32'(if4.e_cnt_o), 32'd0);
        end
        rst = 1'b0;
        m1_e = '0; m1_cnt = '0; m4_e = '0; m4_cnt = '0;
        sb_q.delete();
        // Cleared synchroniser stages present zero operands first.
        for (int i = 0; i < LAT - 1; i++) model_push(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic step(input string tag, input logic a1, b1, d1, input logic [3:0] a4, b4, d4);
        exp_t x;
        drive(a1, b1, d1, a4, b4, d4);
        model_push(a1, b1, d1, a4, b4, d4);
        @(posedge clk); #1;
        if (sb_q.size() == LAT) begin
            x = sb_q.pop_front();
            check({tag, "_E1"},   32'(if1.E_o),     32'(x.e1));
            check({tag, "_C1"},   32'(if1.C_o),     32'(x.c1));
            check({tag, "_chg1"}, 32'(if1.e_chg_o), 32'(x.chg1));
            check({tag, "_cnt1"}, 32'(if1.e_cnt_o), 32'(x.cnt1));
            check({tag, "_E4"},   32'(if4.E_o),     32'(x.e4));
            check({tag, "_C4"},   32'(if4.C_o),     32'(x.c4));
            check({tag, "_chg4"}, 32'(if4.e_chg_o), 32'(x.chg4));
            check({tag, "_cnt4"}, 32'(if4.e_cnt_o), 32'(x.cnt4));
        end else begin
            check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'(LAT));
        end
    endtask

    logic [2:0] tt_vec [7];
    logic [0:0] tt_e   [7];
    logic [0:0] tt_c   [7];
    logic [0:0] tt_chg [7];

    initial begin
        // (A,B,D) truth-table sequence and its fixed expectations after a 0 baseline.
        tt_vec = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b010, 3'b011, 3'b001};
        tt_e   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tt_c   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tt_chg = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        do_reset(2, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF);

        step("rel0", 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF);
        step("rel1", 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF);
        for (int i = 0; i < LAT; i++) step("base", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

        // Truth table: after LAT-1 filler steps the result of vector i is visible.
        for (int i = 0; i < 7; i++) begin
            step("tt", tt_vec[i][2], tt_vec[i][1], tt_vec[i][0], 4'hA, 4'h6, 4'h1);
            if (i >= LAT - 1) begin
                check("tt_E_fixed",   32'(if1.E_o),     32'(tt_e[i - (LAT - 1)]));
                check("tt_C_fixed",   32'(if1.C_o),     32'(tt_c[i - (LAT - 1)]));
                check("tt_chg_fixed", 32'(if1.e_chg_o), 32'(tt_chg[i - (LAT - 1)]));
            end
        end
        for (int i = 0; i < LAT - 1; i++) begin
            step("tt_tail", 1'b0, 1'b0, 1'b1, 4'hA, 4'h6, 4'h1);
            check("tt_E_fixed",   32'(if1.E_o),     32'(tt_e[7 - (LAT - 1) + i]));
            check("tt_C_fixed",   32'(if1.C_o),     32'(tt_c[7 - (LAT - 1) + i]));
            check("tt_chg_fixed", 32'(if1.e_chg_o), 32'(tt_chg[7 - (LAT - 1) + i]));
        end
        check("lane_C4", 32'(if4.C_o), 32'h2);
        check("lane_E4", 32'(if4.E_o), 32'h3);

        // Saturation of the 3-bit counter, then a one-cycle mid-run reset.
        do_reset(1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 12 + LAT; i++) step("sat", 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h8);
        check("sat_cnt1_fixed", 32'(if1.e_cnt_o), 32'd7);
        do_reset(1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h8);
        for (int i = 0; i < 3; i++) step("post_rst", 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h8);

        for (int i = 0; i < 24; i++) begin
            step("rand",
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
